mux16_rr_arbiter: RTL and testbench

Round-robin arbiter and select sequencer for the 16:1 multiplexer datapath. It grants one of 16 requesters at a time, drives the 4-bit select for the shared 16:1 mux, and holds each grant until the requester releases it or a hold timeout expires. The selected data bit is routed to a single shared output line, so 16 sources can time-share that line fairly.

---
 rtl/mux16_rr_arbiter_if.sv | 14 +
 rtl/mux16_rr_arbiter.sv | 79 +++++++
 tb/tb_mux16_rr_arbiter.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/mux16_rr_arbiter_if.sv
// mux16_rr_arbiter_if: request/grant/data bundle shared by the arbiter and its 16 requesters.
interface mux16_rr_arbiter_if;
    logic        en;
    logic [15:0] req;
    logic        done;
    logic [15:0] data_in;
    logic [15:0] grant;
    logic [3:0]  sel;
    logic        busy;
    logic        timeout;
    logic        data_out;
    modport slave (input en, req, done, data_in, output grant, sel, busy, timeout, data_out);
    modport master (output en, req, done, data_in, input grant, sel, busy, timeout, data_out);
endinterface

// File: rtl/mux16_rr_arbiter.sv
// mux16_rr_arbiter: round-robin grant of one of 16 requesters with hold timeout, driving a 16:1 data mux.
module mux16_rr_arbiter #(
    parameter int HOLD_MAX = 8,
    parameter int CNT_W    = 4
) (
    input logic              clk,
    input logic              rst,
    mux16_rr_arbiter_if.slave bus
);
    typedef enum logic {IDLE, GRANT} state_t;
    state_t             state_q, state_d;
    logic [15:0]        grant_q, grant_d;
    logic [3:0]         sel_q, sel_d, ptr_q, ptr_d, off, pick;
    logic               busy_q, busy_d, timeout_q, timeout_d;
    logic [CNT_W-1:0]   hold_q, hold_d;
    logic [15:0]        rot;
    logic               rel_n, rel_t;
    // Rotate requests so bit 0 is the highest-priority channel, then take the lowest set bit.
    always_comb begin
        rot = 16'({bus.req, bus.req} >> ptr_q);
        off = '0;
        for (int j = 15; j >= 0; j--) if (rot[j]) off = 4'(j);
        pick = ptr_q + off;
    end
    assign rel_n = bus.done | ~bus.req[sel_q];
    assign rel_t = (HOLD_MAX != 0) && (hold_q == CNT_W'(HOLD_MAX - 1));
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        sel_d     = sel_q;
        busy_d    = busy_q;
        timeout_d = 1'b0;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        case (state_q)
            IDLE: if (bus.en && |bus.req) begin
                state_d = GRANT;
                grant_d = 16'h1 << pick;
                sel_d   = pick;
                busy_d  = 1'b1;
                hold_d  = '0;
            end
            GRANT: if (rel_n || rel_t) begin
                state_d   = IDLE;
                grant_d   = '0;
                busy_d    = 1'b0;
                ptr_d     = sel_q + 4'd1;
                timeout_d = ~rel_n;
            end else begin
                hold_d = hold_q + CNT_W'(1);
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            sel_q     <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
            ptr_q     <= '0;
            hold_q    <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            sel_q     <= sel_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
        end
    end
    assign bus.grant    = grant_q;
    assign bus.sel      = sel_q;
    assign bus.busy     = busy_q;
    assign bus.timeout  = timeout_q;
    assign bus.data_out = bus.data_in[sel_q] & busy_q;
endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// tb_mux16_rr_arbiter: directed scenarios plus randomized traffic against a behavioural arbiter model.
module tb_mux16_rr_arbiter;
    localparam int HOLD = 8;
    logic clk = 1'b0;
    logic rst = 1'b1;
    mux16_rr_arbiter_if bus();
    mux16_rr_arbiter #(.HOLD_MAX(HOLD), .CNT_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    int passed = 0;
    int total  = 0;
    // Behavioural model: owner index (-1 when idle), priority pointer, cycles already held.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_hold  = 0;
    int m_sel   = 0;
    bit m_to    = 1'b0;
    always @(posedge clk) begin
        m_to = 1'b0;
        if (rst) begin
            m_owner = -1; m_ptr = 0; m_hold = 0; m_sel = 0;
        end else if (m_owner < 0) begin
            if (bus.en && bus.req != 16'h0)
                for (int k = 0; k < 16; k++)
                    if (m_owner < 0 && bus.req[(m_ptr + k) % 16]) begin
                        m_owner = (m_ptr + k) % 16; m_sel = m_owner; m_hold = 0;
                    end
        end else if (bus.done || !bus.req[m_owner]) begin
            m_ptr = (m_owner + 1) % 16; m_owner = -1;
        end else if (HOLD != 0 && m_hold == HOLD - 1) begin
            m_ptr = (m_owner + 1) % 16; m_owner = -1; m_to = 1'b1;
        end else begin
            m_hold++;
        end
    end
    function automatic logic [22:0] exp_vec();
        logic [15:0] g;
        logic b;
        g = (m_owner < 0) ? 16'h0 : 16'h1 << m_owner;
        b = (m_owner >= 0);
        return {g, 4'(m_sel), b, m_to, b & bus.data_in[m_sel]};
    endfunction
    task automatic tick();
        @(negedge clk);
    endtask
    task automatic do_reset();
        rst = 1'b1; tick(); rst = 1'b0;
    endtask
    task automatic test_reset();
        rst = 1'b1; bus.en = 1'b1; bus.req = 16'hFFFF; bus.done = 1'b0;
        tick(); tick();
        total++; if (bus.grant !== 16'h0) $display("FAIL reset_grant: got %h want %h", bus.grant, 16'h0); else passed++;
        total++; if (bus.sel !== 4'h0) $display("FAIL reset_sel: got %h want %h", bus.sel, 4'h0); else passed++;
        total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else passed++;
        total++; if (bus.timeout !== 1'b0) $display("FAIL reset_timeout: got %b want 0", bus.timeout); else passed++;
        rst = 1'b0; tick();
        total++; if (bus.grant !== 16'h0001) $display("FAIL reset_first_grant: got %h want %h", bus.grant, 16'h0001); else passed++;
        bus.done = 1'b1; tick(); bus.done = 1'b0; bus.req = 16'h0; tick();
    endtask
    task automatic test_single();
        do_reset();
        bus.req = 16'h0020; tick();
        total++; if (bus.grant !== 16'h0020 || bus.sel !== 4'd5) $display("FAIL single_grant: got %h/%0d want 0020/5", bus.grant, bus.sel); else passed++;
        tick();
        total++; if (bus.grant !== 16'h0020) $display("FAIL single_hold2: got %h want 0020", bus.grant); else passed++;
        tick();
        total++; if (bus.grant !== 16'h0020) $display("FAIL single_hold3: got %h want 0020", bus.grant); else passed++;
        bus.done = 1'b1; tick(); bus.done = 1'b0;
        total++; if (bus.grant !== 16'h0 || bus.timeout !== 1'b0) $display("FAIL single_release: got %h/%b want 0000/0", bus.grant, bus.timeout); else passed++;
        bus.req = 16'h0; tick();
    endtask
    task automatic test_round_robin();
        int order[5] = '{0, 5, 15, 0, 5};
        do_reset();
        bus.req = 16'h8021;
        for (int k = 0; k < 5; k++) begin
            tick();
            total++; if (bus.grant !== 16'h1 << order[k] || bus.sel !== 4'(order[k])) $display("FAIL rr_grant%0d: got %h/%0d want ch %0d", k, bus.grant, bus.sel, order[k]); else passed++;
            bus.done = 1'b1; tick(); bus.done = 1'b0;
            total++; if (bus.grant !== 16'h0) $display("FAIL rr_bubble%0d: got %h want 0000", k, bus.grant); else passed++;
        end
        bus.req = 16'h0; tick();
    endtask
    task automatic test_timeout();
        int cnt = 1;
        do_reset();
        bus.req = 16'h0208; tick();
        for (int k = 0; k < 20; k++) begin
            tick();
            if (bus.grant === 16'h0008) cnt++; else break;
        end
        total++; if (cnt != HOLD) $display("FAIL to_length: got %0d want %0d", cnt, HOLD); else passed++;
        total++; if (bus.timeout !== 1'b1 || bus.grant !== 16'h0) $display("FAIL to_pulse: got %b/%h want 1/0000", bus.timeout, bus.grant); else passed++;
        tick();
        total++; if (bus.timeout !== 1'b0 || bus.grant !== 16'h0200) $display("FAIL to_next: got %b/%h want 0/0200", bus.timeout, bus.grant); else passed++;
        bus.done = 1'b1; tick(); bus.done = 1'b0; tick();
        total++; if (bus.grant !== 16'h0008) $display("FAIL to_return: got %h want 0008", bus.grant); else passed++;
        bus.req = 16'h0; tick();
    endtask
    task automatic test_datapath();
        do_reset();
        bus.data_in = 16'h3f0a; bus.req = 16'h0002; tick();
        total++; if (bus.data_out !== 1'b1) $display("FAIL dp_ch1: got %b want 1", bus.data_out); else passed++;
        bus.done = 1'b1; tick(); bus.done = 1'b0;
        total++; if (bus.data_out !== 1'b0) $display("FAIL dp_idle: got %b want 0", bus.data_out); else passed++;
        bus.req = 16'h0001; tick();
        total++; if (bus.grant !== 16'h0001 || bus.data_out !== 1'b0) $display("FAIL dp_ch0: got %h/%b want 0001/0", bus.grant, bus.data_out); else passed++;
        for (int k = 0; k < HOLD - 1; k++) tick();
        total++; if (bus.grant !== 16'h0001) $display("FAIL dp_last_cycle: got %h want 0001", bus.grant); else passed++;
        bus.done = 1'b1; tick(); bus.done = 1'b0;
        total++; if (bus.grant !== 16'h0 || bus.timeout !== 1'b0) $display("FAIL dp_collision: got %h/%b want 0000/0", bus.grant, bus.timeout); else passed++;
        bus.req = 16'h0; tick();
    endtask
    task automatic test_mid_reset();
        do_reset();
        bus.req = 16'h0080; tick();
        bus.done = 1'b1; tick(); bus.done = 1'b0;
        bus.req = 16'h1010; tick();
        total++; if (bus.grant !== 16'h1000) $display("FAIL mr_ch12: got %h want 1000", bus.grant); else passed++;
        tick(); tick();
        rst = 1'b1; tick();
        total++; if (bus.grant !== 16'h0 || bus.busy !== 1'b0 || bus.sel !== 4'h0) $display("FAIL mr_reset: got %h/%b/%0d want 0000/0/0", bus.grant, bus.busy, bus.sel); else passed++;
        rst = 1'b0; tick();
        total++; if (bus.grant !== 16'h0010 || bus.sel !== 4'd4) $display("FAIL mr_after: got %h/%0d want 0010/4", bus.grant, bus.sel); else passed++;
        bus.done = 1'b1; tick(); bus.done = 1'b0; bus.req = 16'h0; tick();
    endtask
    task automatic test_en_low();
        do_reset();
        bus.en = 1'b1; bus.req = 16'h0004; tick();
        bus.en = 1'b0; bus.req = 16'h0014;
        for (int k = 0; k < 3; k++) begin
            tick();
            total++; if (bus.grant !== 16'h0004) $display("FAIL en_hold%0d: got %h want 0004", k, bus.grant); else passed++;
        end
        bus.done = 1'b1; tick(); bus.done = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            total++; if (bus.grant !== 16'h0 || bus.busy !== 1'b0) $display("FAIL en_blocked%0d: got %h/%b want 0000/0", k, bus.grant, bus.busy); else passed++;
        end
        bus.en = 1'b1; tick();
        total++; if (bus.grant !== 16'h0010) $display("FAIL en_resume: got %h want 0010", bus.grant); else passed++;
        bus.done = 1'b1; tick(); bus.done = 1'b0; bus.req = 16'h0; tick();
    endtask
    task automatic test_random();
        logic [22:0] act, exp;
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 199) == 0);
            bus.en = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 9) < 3) bus.req = 16'($urandom & $urandom);
            bus.done = ($urandom_range(0, 5) == 0);
            bus.data_in = 16'($urandom);
            tick();
            act = {bus.grant, bus.sel, bus.busy, bus.timeout, bus.data_out};
            exp = exp_vec();
            total++; if (act !== exp) $display("FAIL rand_cycle%0d: got %h want %h", n, act, exp); else passed++;
            total++; if ($countones(bus.grant) > 1 || ((bus.grant != 16'h0) !== bus.busy)) $display("FAIL rand_onehot%0d: got %h/%b want onehot matching busy", n, bus.grant, bus.busy); else passed++;
        end
        rst = 1'b0; bus.req = 16'h0; bus.done = 1'b0; tick();
    endtask
    initial begin
        bus.en = 1'b1; bus.req = 16'h0; bus.done = 1'b0; bus.data_in = 16'h0;
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_datapath();
        test_mid_reset();
        test_en_low();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
